// File: rtl/div_12_if.sv
// Operand/result bundle for div_12, shared by the divider and whoever feeds it.
// Handshake: operands transfer on a rising edge where valid_i=1 and ready_o=1; valid_o is a one-cycle result strobe.
interface div_12_if;
   logic        valid_i;
   logic        ready_o;
   logic [11:0] data_1_i;
   logic [11:0] data_2_i;
   logic        valid_o;
   logic [11:0] data_div_o;
   logic [1:0]  dbg_state;

   modport slave  (input  valid_i, data_1_i, data_2_i,
                   output ready_o, valid_o, data_div_o, dbg_state);
   modport master (output valid_i, data_1_i, data_2_i,
                   input  ready_o, valid_o, data_div_o, dbg_state);
endinterface

// File: rtl/div_12.sv
// 12-bit float divider (1/5/6, bias 15): 8-step restoring mantissa division,
// fixed 10-cycle turnaround, truncating, with zero/overflow/underflow handling.
module div_12 (
   input  logic      clk_i,
   input  logic      rst_i,
   div_12_if.slave   bus
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_DIV = 2'd1, S_NORM = 2'd2} state_t;

   state_t      r_state;
   state_t      w_next;
   logic        r_sign;
   logic [4:0]  r_ea;
   logic [4:0]  r_eb;
   logic [6:0]  r_b;
   logic [7:0]  r_r;
   logic [7:0]  r_q;
   logic [2:0]  r_cnt;
   logic [11:0] r_data;
   logic        r_valid;

   logic        w_accept;
   logic        w_ge;
   logic [7:0]  w_diff;
   logic        w_n;
   logic [5:0]  w_mant;
   logic [6:0]  w_exp;
   logic        w_exp_low;
   logic        w_exp_high;
   logic [11:0] w_result;

   assign w_accept = (r_state == S_IDLE) && bus.valid_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (bus.valid_i) w_next = S_DIV;
         S_DIV:   if (r_cnt == 3'd7) w_next = S_NORM;
         S_NORM:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // r never exceeds 2B-1, so the 8-bit remainder cannot overflow on the shift.
   assign w_ge   = r_r >= {1'b0, r_b};
   assign w_diff = r_r - {1'b0, r_b};

   // q in (0.5, 2): a clear top bit means one extra normalising shift.
   assign w_n        = ~r_q[7];
   assign w_mant     = r_q[7] ? r_q[6:1] : r_q[5:0];
   assign w_exp      = {2'b00, r_ea} - {2'b00, r_eb} + 7'd15 - {6'd0, w_n};
   assign w_exp_low  = w_exp[6] || (w_exp == 7'd0);
   assign w_exp_high = !w_exp[6] && (w_exp >= 7'd31);

   always_comb begin
      w_result = {r_sign, w_exp[4:0], w_mant};
      if (r_eb == 5'd0)     w_result = {r_sign, 5'd31, 6'd0};
      else if (r_ea == 5'd0) w_result = 12'h000;
      else if (w_exp_low)   w_result = 12'h000;
      else if (w_exp_high)  w_result = {r_sign, 5'd31, 6'd0};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_sign  <= 1'b0;
         r_ea    <= 5'd0;
         r_eb    <= 5'd0;
         r_b     <= 7'd0;
         r_r     <= 8'd0;
         r_q     <= 8'd0;
         r_cnt   <= 3'd0;
         r_data  <= 12'h000;
         r_valid <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_sign <= bus.data_1_i[11] ^ bus.data_2_i[11];
                  r_ea   <= bus.data_1_i[10:6];
                  r_eb   <= bus.data_2_i[10:6];
                  r_b    <= {1'b1, bus.data_2_i[5:0]};
                  r_r    <= {2'b01, bus.data_1_i[5:0]};
                  r_q    <= 8'd0;
                  r_cnt  <= 3'd0;
               end
            end
            S_DIV: begin
               if (w_ge) begin
                  r_q <= r_q | (8'h80 >> r_cnt);
                  r_r <= w_diff << 1;
               end else begin
                  r_r <= r_r << 1;
               end
               r_cnt <= r_cnt + 3'd1;
            end
            S_NORM: begin
               r_data  <= w_result;
               r_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.ready_o    = (r_state == S_IDLE);
   assign bus.valid_o    = r_valid;
   assign bus.data_div_o = r_data;
   assign bus.dbg_state  = r_state;

endmodule
